// File: rtl/imersiv_nn_key_in.sv
// Avalon-MM parallel input port: synchronizes external key lines, latches
// rising edges into a write-1-to-clear capture register and raises a masked irq.
module imersiv_nn_key_in #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  logic [WIDTH-1:0] sync1, sync2, sync3;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clear_bits;
  logic             write_en;
  logic [31:0]      read_word;
  logic             unused_writedata;

  // Only the low WIDTH bits of writedata carry meaning.
  assign unused_writedata = ^writedata;

  assign write_en = chipselect & ~write_n;
  assign rise     = sync2 & ~sync3;

  // NOTE: every register here is a plain flop, so all of them (including
  // sync3) take the async reset; non-blocking assignments keep the
  // synchronizer stages sampling their predecessor's old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (write_en && address == ADDR_MASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign clear_bits = (write_en && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  // A rise arriving in the same cycle as a clear wins, so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | rise;
    end
  end

  // NOTE: read_word gets a full default before the case so no latch is inferred
  // and the upper bits are zero-extended for any WIDTH up to 32.
  always_comb begin
    read_word = '0;
    case (address)
      ADDR_DATA:    read_word[WIDTH-1:0] = sync2;
      ADDR_MASK:    read_word[WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE: read_word[WIDTH-1:0] = edge_capture;
      default:      read_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_word;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_imersiv_nn_key_in.sv
// Directed bench for imersiv_nn_key_in: register map, edge capture timing,
// set-over-clear priority, falling-edge rejection and mid-run reset.
module tb_imersiv_nn_key_in;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int tests_run    = 0;
  int tests_failed = 0;

  imersiv_nn_key_in #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    step(1);
    d = readdata;
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 16'h0005;
    #3;
    tests_run++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: readdata=%h irq=%b, required 00000000/0", readdata, irq);
    end
    step(3);
    tests_run++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_held: readdata=%h irq=%b, required 00000000/0", readdata, irq);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_data_read;
    logic [31:0] d;
    address = 2'd0;
    step(4);
    tests_run++;
    if (readdata !== 32'h0000_0005) begin
      tests_failed++;
      $display("FAIL data_read: got %h, required 00000005", readdata);
    end
    bus_read(2'd1, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reserved_read: got %h, required 00000000", d);
    end
    // Bits already high at reset release are captured as rising edges.
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0000_0005 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_capture: capture=%h irq=%b, required 00000005/0", d, irq);
    end
    bus_read(2'd2, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL mask_reset_value: got %h, required 00000000", d);
    end
    bus_write(2'd3, 32'h0000_FFFF);
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL w1c_all: capture=%h, required 00000000", d);
    end
  endtask

  task automatic test_ignored_writes;
    logic [31:0] d;
    bus_write(2'd2, 32'h0000_1234);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    // A strobe without chipselect must not reach the mask.
    address = 2'd2; writedata = 32'h0000_FFFF; write_n = 1'b0; chipselect = 1'b0;
    step(1);
    write_n = 1'b1; writedata = '0;
    bus_read(2'd2, d);
    tests_run++;
    if (d !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL ignored_writes_mask: got %h, required 00001234", d);
    end
    bus_read(2'd1, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL ignored_writes_reserved: got %h, required 00000000", d);
    end
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_writes_capture: capture=%h irq=%b, required 00000000/0", d, irq);
    end
  endtask

  task automatic test_irq_pulse;
    logic [31:0] d;
    bus_write(2'd2, 32'h0000_0002);
    bus_read(2'd2, d);
    tests_run++;
    if (d !== 32'h0000_0002) begin
      tests_failed++;
      $display("FAIL mask_write: got %h, required 00000002", d);
    end
    address = 2'd3;
    in_port = 16'h0007;
    step(2);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_early: irq=%b after 2 edges, required 0", irq);
    end
    step(1);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_latency: irq=%b after 3 edges, required 1", irq);
    end
    in_port = 16'h0005;
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0000_0002) begin
      tests_failed++;
      $display("FAIL pulse_capture: capture=%h, required 00000002", d);
    end
    step(3);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_sticky: irq=%b after input fell, required 1", irq);
    end
    bus_write(2'd3, 32'h0000_0002);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: irq=%b, required 0", irq);
    end
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL pulse_cleared: capture=%h, required 00000000", d);
    end
  endtask

  task automatic test_masked_capture;
    logic [31:0] d;
    bus_write(2'd2, 32'h0000_0000);
    in_port = 16'h000D;
    step(4);
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0000_0008 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL masked_capture: capture=%h irq=%b, required 00000008/0", d, irq);
    end
    bus_write(2'd2, 32'h0000_0008);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmask_irq: irq=%b, required 1", irq);
    end
    bus_write(2'd3, 32'h0000_0008);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL unmask_clear: irq=%b, required 0", irq);
    end
  endtask

  task automatic test_set_over_clear;
    logic [31:0] d;
    bus_write(2'd2, 32'h0000_0001);
    in_port = 16'h000C;
    step(4);
    in_port = 16'h000D;
    step(3);
    in_port = 16'h000C;
    step(4);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL bit0_pending: irq=%b, required 1", irq);
    end
    // The rise is detected in the cycle ending at the third edge; the clear lands on that edge.
    in_port = 16'h000D;
    step(2);
    bus_write(2'd3, 32'h0000_0001);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_over_clear_irq: irq=%b, required 1", irq);
    end
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL set_over_clear_capture: capture=%h, required 00000001", d);
    end
    bus_write(2'd3, 32'h0000_0001);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL steady_level_clear: irq=%b, required 0", irq);
    end
  endtask

  task automatic test_falling_edge;
    logic [31:0] d;
    bus_write(2'd2, 32'h0000_FFFF);
    in_port = 16'h0009;
    step(5);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL falling_irq: irq=%b, required 0", irq);
    end
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL falling_capture: capture=%h, required 00000000", d);
    end
    bus_read(2'd0, d);
    tests_run++;
    if (d !== 32'h0000_0009) begin
      tests_failed++;
      $display("FAIL falling_data: got %h, required 00000009", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    in_port = 16'h00F0;
    step(4);
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0000_00F0 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_capture: capture=%h irq=%b, required 000000F0/1", d, irq);
    end
    reset_n = 1'b0;
    step(1);
    tests_run++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: readdata=%h irq=%b, required 00000000/0", readdata, irq);
    end
    reset_n = 1'b1;
    bus_read(2'd2, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_mask: got %h, required 00000000", d);
    end
    bus_read(2'd3, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_capture_cleared: capture=%h, required 00000000", d);
    end
    step(2);
    tests_run++;
    if (readdata !== 32'h0000_00F0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_recapture: capture=%h irq=%b, required 000000F0/0", readdata, irq);
    end
  endtask

  initial begin
    test_reset;
    test_data_read;
    test_ignored_writes;
    test_irq_pulse;
    test_masked_capture;
    test_set_over_clear;
    test_falling_edge;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
